// File: rtl/mac_accumulator.sv
// Neuron accumulator: bias + sum of N_IN signed products with saturation,
// then a ReLU with a high clip onto an OUT_W-bit result behind a valid/ready handshake.
module mac_accumulator #(
    parameter int BITS  = 32,
    parameter int N_IN  = 4,
    parameter int ACC_W = BITS + 24,
    parameter int OUT_W = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic signed [31:0]      bias,
    input  logic                    prod_valid,
    input  logic signed [BITS+16:0] prod,
    output logic                    prod_ready,
    output logic signed [OUT_W-1:0] y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    ovf
);

    typedef enum logic [1:0] {IDLE, ACC, FINAL, OUT} state_t;

    localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN - 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [ACC_W-1:0] Y_MAX   = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};

    state_t                  state;
    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;

    // One guard bit: overflow shows up as the top two bits disagreeing.
    logic signed [ACC_W:0] sum;
    logic                  sat_hi, sat_lo;
    logic signed [ACC_W-1:0] acc_next;

    always_comb begin
        sum      = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);
        sat_hi   = ~sum[ACC_W] &  sum[ACC_W-1];
        sat_lo   =  sum[ACC_W] & ~sum[ACC_W-1];
        acc_next = sat_hi ? ACC_MAX : (sat_lo ? ACC_MIN : sum[ACC_W-1:0]);
    end

    assign prod_ready = (state == ACC);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            y         <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    acc   <= ACC_W'(bias);
                    cnt   <= '0;
                    ovf   <= 1'b0;
                    state <= ACC;
                end
                ACC: if (prod_valid) begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (sat_hi || sat_lo) ovf <= 1'b1;
                    if (cnt == CNT_LAST) state <= FINAL;
                end
                FINAL: begin
                    if (acc < 0) begin
                        y <= '0;
                    end else if (acc > Y_MAX) begin
                        y   <= Y_MAX[OUT_W-1:0];
                        ovf <= 1'b1;
                    end else begin
                        y <= acc[OUT_W-1:0];
                    end
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed and randomized neuron runs against two accumulator widths, checked
// against a plain-arithmetic model of bias + saturating sum + ReLU/clip.
module tb_mac_accumulator;
    localparam int BITS = 32, N = 4, OUT_W = 32;
    localparam int AW_A = BITS + 24, AW_B = BITS + 17;

    logic clk = 0, rstn = 0, start = 0, prod_valid = 0, out_ready = 0;
    logic signed [31:0] bias = 0;
    logic signed [BITS+16:0] prod = 0;
    logic pr_a, ov_a, busy_a, ovf_a, pr_b, ov_b, busy_b, ovf_b;
    logic signed [OUT_W-1:0] y_a, y_b;

    int n_cmp = 0, n_err = 0;
    longint prods[N];
    longint exp_y[2];
    bit     exp_ovf[2];

    always #5 clk = ~clk;

    mac_accumulator #(.BITS(BITS), .N_IN(N), .ACC_W(AW_A), .OUT_W(OUT_W)) dut_a (
        .clk(clk), .rstn(rstn), .start(start), .bias(bias), .prod_valid(prod_valid),
        .prod(prod), .prod_ready(pr_a), .y(y_a), .out_valid(ov_a), .out_ready(out_ready),
        .busy(busy_a), .ovf(ovf_a));

    mac_accumulator #(.BITS(BITS), .N_IN(N), .ACC_W(AW_B), .OUT_W(OUT_W)) dut_b (
        .clk(clk), .rstn(rstn), .start(start), .bias(bias), .prod_valid(prod_valid),
        .prod(prod), .prod_ready(pr_b), .y(y_b), .out_valid(ov_b), .out_ready(out_ready),
        .busy(busy_b), .ovf(ovf_b));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: clamp every partial sum to the signed w-bit range, then ReLU and clip.
    task automatic model(input longint b, input int idx, input int w);
        longint mx = (64'sd1 <<< (w - 1)) - 1;
        longint mn = -mx - 1;
        longint ymax = (64'sd1 <<< (OUT_W - 1)) - 1;
        longint a = b;
        bit o = 0;
        for (int i = 0; i < N; i++) begin
            a = a + prods[i];
            if (a > mx) begin a = mx; o = 1; end
            if (a < mn) begin a = mn; o = 1; end
        end
        if (a < 0) exp_y[idx] = 0;
        else if (a > ymax) begin exp_y[idx] = ymax; o = 1; end
        else exp_y[idx] = a;
        exp_ovf[idx] = o;
    endtask

    task automatic chk_out(input string tag);
        chk({tag, ".y_a"}, 64'(unsigned'(y_a)), exp_y[0]);
        chk({tag, ".ovf_a"}, 64'(ovf_a), 64'(exp_ovf[0]));
        chk({tag, ".y_b"}, 64'(unsigned'(y_b)), exp_y[1]);
        chk({tag, ".ovf_b"}, 64'(ovf_b), 64'(exp_ovf[1]));
    endtask

    task automatic run(input string tag, input longint b, input int stall, input int hold, input bit pulse);
        model(b, 0, AW_A);
        model(b, 1, AW_B);
        bias = 32'(b); start = 1;
        @(negedge clk); start = 0; bias = 32'hdead_beef;
        chk({tag, ".ready"}, 64'({pr_a, pr_b, busy_a}), 64'b111);
        for (int i = 0; i < N; i++) begin
            prod_valid = 1; prod = 49'(prods[i]);
            @(negedge clk); prod_valid = 0; prod = '0;
            if (i < N - 1)
                for (int s = 0; s < stall; s++) begin
                    if (s == 0) start = pulse;
                    @(negedge clk); start = 0;
                    chk({tag, ".stall"}, 64'({pr_a, ov_a, pr_b}), 64'b101);
                end
        end
        chk({tag, ".final"}, 64'({ov_a, ov_b, busy_a, pr_a}), 64'b0010);
        @(negedge clk);
        chk({tag, ".valid"}, 64'({ov_a, ov_b}), 64'b11);
        chk_out(tag);
        for (int h = 0; h < hold; h++) begin
            if (h == 0) start = pulse;
            @(negedge clk); start = 0;
            chk({tag, ".hold"}, 64'({ov_a, ov_b, busy_a}), 64'b111);
            chk_out({tag, ".hold"});
        end
        out_ready = 1;
        @(negedge clk); out_ready = 0;
        chk({tag, ".idle"}, 64'({ov_a, busy_a, ov_b, busy_b, pr_a}), 64'b0);
        chk_out({tag, ".idle"});
    endtask

    initial begin
        #12;
        chk("reset", 64'({y_a, ovf_a, ov_a, pr_a, busy_a}), 64'b0);
        @(negedge clk); rstn = 1;
        @(negedge clk);

        prods = '{5, -3, 7, 1};
        run("basic", 10, 0, 0, 0);
        prods = '{10, 10, 10, 10};
        run("relu", -100, 0, 0, 0);
        prods = '{64'sd1 <<< 31, 64'sd1 <<< 31, 64'sd1 <<< 31, 64'sd1 <<< 31};
        run("clip", 0, 0, 0, 0);
        prods = '{3, 4, 5, 6};
        run("stall", 100, 3, 5, 1);
        // Full-range products drive the narrow accumulator into saturation.
        prods = '{(64'sd1 <<< 48) - 1, (64'sd1 <<< 48) - 1, 64'sd7, 64'sd0};
        run("sat_hi", 0, 1, 0, 0);
        prods = '{-(64'sd1 <<< 48), -(64'sd1 <<< 48), (64'sd1 <<< 48) - 1, 64'sd100};
        run("sat_lo", -5, 0, 1, 0);

        for (int t = 0; t < 12; t++) begin
            for (int i = 0; i < N; i++) begin
                longint p = longint'({$urandom, $urandom});
                p = (t % 2 == 0) ? ((p <<< 15) >>> 15) : ((p <<< 40) >>> 40);
                prods[i] = p;
            end
            run("rand", longint'(signed'($urandom)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
        end

        // Reset mid-neuron after the previous output left y nonzero.
        prods = '{5, -3, 7, 1};
        run("pre_rst", 10, 0, 0, 0);
        bias = 50; start = 1;
        @(negedge clk); start = 0;
        for (int i = 0; i < 2; i++) begin
            prod_valid = 1; prod = 49'(1000);
            @(negedge clk);
        end
        prod_valid = 0;
        #2 rstn = 0;
        #1 chk("async_rst", 64'({y_a, ovf_a, ov_a, pr_a, busy_a, busy_b}), 64'b0);
        @(negedge clk); rstn = 1;
        @(negedge clk);
        prods = '{1, 1, 1, 1};
        run("post_rst", 1, 0, 0, 0);
        chk("post_rst.y5", 64'(unsigned'(y_a)), 64'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
